pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised pipeline stage register; next generation of the fixed 32-bit IF/ID latch.
//  Carries a W-bit payload plus PC between stages with valid/ready flow control and hazard stall/flush.
//  A 2-entry skid buffer keeps upstream ready registered, so no combinational ready path crosses stages.
//  Adds saturating stall/flush counters for the hazard unit. Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  W            32          payload width (instruction or control bundle)
//  AW           32          PC width
//  BUBBLE       {W{1'b0}}   payload value for an empty or flushed stage (NOP)
//  CLR_ON_DRAIN 1           1: main reg loads BUBBLE when drained with no refill; 0: holds last value
//  CW           16          perf counter width
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-low reset
//  in_valid   in   1    upstream beat valid
//  in_ready   out  1    stage can accept; registered
//  in_data    in   W    upstream payload
//  in_pc      in   AW   upstream PC
//  stall      in   1    hazard-unit hold; blocks out_fire
//  flush      in   1    hazard-unit squash; synchronous
//  out_valid  out  1    main entry valid
//  out_ready  in   1    downstream can accept
//  out_data   out  W    main entry payload
//  out_pc     out  AW   main entry PC
//  cnt_clr    in   1    synchronous clear of both counters
//  stall_cnt  out  CW   cycles with out_valid & stall
//  flush_cnt  out  CW   cycles with flush asserted
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~stall.
//  - Reset (async, reset==0): state EMPTY, out_valid=0, out_data=BUBBLE, out_pc=0, skid cleared,
//    in_ready=1, counters=0. Reset wins over everything, including mid-transfer.
//  - States: EMPTY (main invalid), FULL (main valid), SKID (main+skid valid).
//  - EMPTY: in_fire -> FULL, main<=in.
//  - FULL: in_fire&out_fire -> FULL, main<=in; in_fire&~out_fire -> SKID, skid<=in;
//    ~in_fire&out_fire -> EMPTY (main<=BUBBLE/0 if CLR_ON_DRAIN); else hold.
//  - SKID: out_fire -> FULL, main<=skid; else hold. in_ready=0 in SKID only.
//  - in_ready is a flop: next value = (next_state != SKID). Latency in->out = 1 cycle.
//  - flush has priority over stall and all transfers: next state EMPTY, main and skid <= BUBBLE/0,
//    out_valid<=0. A beat presented with in_fire in the flush cycle is consumed and discarded.
//  - stall holds state exactly: no out_fire; in_fire still accepted into free entry (FULL -> SKID).
//  - stall & flush together: flush wins (squash of a held wrong-path instruction).
//  - Counters saturate at 2^CW-1; cnt_clr has priority over increment.
//  - Payload and PC are opaque; no arithmetic on them.
// STRUCTURE
//  - pipe_defs.vh: localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2; shared NOP encoding for BUBBLE.
//  - Sub-module sat_counter (CW, inc, clr -> cnt), instantiated twice.
//  - Top: 2-bit state reg, main {data,pc}, skid {data,pc}, in_ready flop.
// TESTING
//  1. Reset mid-stream with SKID occupied -> out_valid=0, out_data=BUBBLE, in_ready=1 immediately.
//  2. Stream 0x11,0x22,0x33 with out_ready=1, stall=0 -> outputs 0x11,0x22,0x33 one cycle later, no gaps.
//  3. stall=1 for 3 cycles while feeding 0x44,0x55 -> out holds 0x44, in_ready drops after 0x55,
//     stall_cnt=3; release -> 0x44 then 0x55 in order.
//  4. flush with stall=1 in SKID state -> next cycle out_valid=0, out_data=BUBBLE, state EMPTY, flush_cnt=1.
//  5. Saturation with CW=2: stall 6 cycles -> stall_cnt=3; cnt_clr -> 0 next cycle.
//  6. Random valid/ready/stall/flush vs scoreboard model -> no loss, duplication or reorder outside flushes.

Source files
------------

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and
// the default NOP fill used for empty or squashed stages.
package pipe_stage_elastic_pkg;

    // Occupancy of the stage: main entry only, or main plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // Fill bit replicated across the payload when no parameter override is given.
    localparam logic NOP_FILL_BIT = 1'b0;

    // True when the given state exposes a valid beat downstream.
    function automatic logic state_has_beat(input stage_state_e st);
        return (st != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating event counter used for the hazard-unit stall/flush statistics.
module pipe_stage_elastic_sat_counter
    import pipe_stage_elastic_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with a two-entry skid buffer, so that the
// upstream ready is a flop, plus hazard stall/flush and saturating counters.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int           W            = 32,
    parameter int           AW           = 32,
    parameter logic [W-1:0] BUBBLE       = {W{NOP_FILL_BIT}},
    parameter bit           CLR_ON_DRAIN = 1'b1,
    parameter int           CW           = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_pc,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW-1:0] out_pc,
    input  logic          cnt_clr,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    stage_state_e  state;
    stage_state_e  next_state;
    logic [W-1:0]  main_data;
    logic [AW-1:0] main_pc;
    logic [W-1:0]  skid_data;
    logic [AW-1:0] skid_pc;
    logic          in_ready_q;
    logic          in_fire;
    logic          out_fire;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid_in;
    logic          clear_main;
    logic          clear_all;

    assign in_ready  = in_ready_q;
    assign out_valid = state_has_beat(state);
    assign out_data  = main_data;
    assign out_pc    = main_pc;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready & ~stall;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy transitions; a flush empties the stage regardless of handshakes.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) next_state = ST_FULL;
                ST_FULL: begin
                    if (in_fire && !out_fire) begin
                        next_state = ST_SKID;
                    end else if (!in_fire && out_fire) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_SKID:  if (out_fire) next_state = ST_FULL;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    // Datapath load strobes derived from the current state and handshakes.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        clear_main     = 1'b0;
        clear_all      = flush;
        if (!flush) begin
            case (state)
                ST_EMPTY: load_main_in = in_fire;
                ST_FULL: begin
                    load_main_in = in_fire & out_fire;
                    load_skid_in = in_fire & ~out_fire;
                    clear_main   = ~in_fire & out_fire & CLR_ON_DRAIN;
                end
                ST_SKID:  load_main_skid = out_fire;
                default:  clear_main = 1'b0;
            endcase
        end
    end

    // Main and skid payload/PC registers; squashed or drained entries read as the NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data <= BUBBLE;
            main_pc   <= '0;
            skid_data <= BUBBLE;
            skid_pc   <= '0;
        end else if (clear_all) begin
            main_data <= BUBBLE;
            main_pc   <= '0;
            skid_data <= BUBBLE;
            skid_pc   <= '0;
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
                main_pc   <= in_pc;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_pc   <= skid_pc;
            end else if (clear_main) begin
                main_data <= BUBBLE;
                main_pc   <= '0;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
                skid_pc   <= in_pc;
            end
        end
    end

    // Upstream ready is registered: it drops only while the skid entry is occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (next_state != ST_SKID);
        end
    end

    pipe_stage_elastic_sat_counter #(.CW(CW)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & stall),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    pipe_stage_elastic_sat_counter #(.CW(CW)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: a reference model queues accepted
// beats, a negedge monitor compares the stage outputs against the queue head.
module tb_pipe_stage_elastic;

    localparam int           W      = 32;
    localparam int           AW     = 32;
    localparam int           CW     = 16;
    localparam logic [W-1:0] BUBBLE = 32'h0000_0013;
    localparam int           CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] pc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_pc = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_pc;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    // Small second instance with 2-bit counters for the saturation check.
    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [7:0]    s_in_data = 8'h3C;
    logic [7:0]    s_in_pc = 8'h04;
    logic          s_stall = 1'b0;
    logic          s_flush = 1'b0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b0;
    logic [7:0]    s_out_data;
    logic [7:0]    s_out_pc;
    logic          s_cnt_clr = 1'b0;
    logic [1:0]    s_stall_cnt;
    logic [1:0]    s_flush_cnt;

    beat_t exp_q[$];
    int    exp_stall = 0;
    int    exp_flush = 0;
    int    vectors = 0;
    int    miscompares = 0;

    pipe_stage_elastic #(.W(W), .AW(AW), .BUBBLE(BUBBLE), .CLR_ON_DRAIN(1'b1), .CW(CW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pc    (out_pc),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_stage_elastic #(.W(8), .AW(8), .BUBBLE(8'hA5), .CLR_ON_DRAIN(1'b1), .CW(2)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .in_pc     (s_in_pc),
        .stall     (s_stall),
        .flush     (s_flush),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .out_pc    (s_out_pc),
        .cnt_clr   (s_cnt_clr),
        .stall_cnt (s_stall_cnt),
        .flush_cnt (s_flush_cnt)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one set of inputs for exactly one rising edge, changing them 2ns after the edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [AW-1:0] p,
                                 input logic st, input logic fl, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_pc     = p;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        cnt_clr   = clr;
        @(posedge clk);
        #2;
    endtask

    // Reference model: tracks accepted beats and counter values edge by edge.
    always @(posedge clk or negedge reset) begin
        bit occupied;
        bit m_in_fire;
        bit m_out_fire;
        if (!reset) begin
            exp_q.delete();
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            occupied   = (exp_q.size() > 0);
            m_in_fire  = in_valid && (exp_q.size() < 2);
            m_out_fire = occupied && out_ready && !stall;
            if (cnt_clr) exp_stall = 0;
            else if (occupied && stall && exp_stall < CNT_MAX) exp_stall++;
            if (cnt_clr) exp_flush = 0;
            else if (flush && exp_flush < CNT_MAX) exp_flush++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_out_fire) void'(exp_q.pop_front());
                if (m_in_fire) exp_q.push_back('{data: in_data, pc: in_pc});
            end
        end
    end

    // Monitor: away from the active edge, the stage must present the model's head beat.
    always @(negedge clk) begin
        checkOutput("out_valid", out_valid, exp_q.size() > 0);
        checkOutput("in_ready", in_ready, exp_q.size() < 2);
        if (exp_q.size() > 0) begin
            checkOutput("out_data", out_data, exp_q[0].data);
            checkOutput("out_pc", out_pc, exp_q[0].pc);
        end else begin
            checkOutput("out_data_bubble", out_data, BUBBLE);
            checkOutput("out_pc_zero", out_pc, '0);
        end
        checkOutput("stall_cnt", stall_cnt, exp_stall);
        checkOutput("flush_cnt", flush_cnt, exp_flush);
    end

    initial begin
        // Start in reset, then release away from the clock edge.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_data", out_data, BUBBLE);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        reset = 1'b1;

        // Back-to-back stream with the downstream always ready.
        applyStimulus(1'b1, 32'h11, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h22, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h33, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("stream_last", out_data, 32'h33);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Stall while two beats arrive: 0x44 held, 0x55 parked in the skid entry.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h44, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h55, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_held_data", out_data, 32'h44);
        checkOutput("stall_in_ready", in_ready, 1'b0);
        checkOutput("stall_cnt_3", stall_cnt, 16'd3);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("release_first", out_data, 32'h55);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush together with stall while the skid entry is occupied.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h66, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h77, 32'h304, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_out_valid", out_valid, 1'b0);
        checkOutput("flush_out_data", out_data, BUBBLE);
        checkOutput("flush_in_ready", in_ready, 1'b1);
        checkOutput("flush_cnt_1", flush_cnt, 16'd1);

        // A beat accepted in the flush cycle is discarded.
        applyStimulus(1'b1, 32'h88, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h99, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_discard", out_valid, 1'b0);

        // Reset asserted mid-stream with the skid entry occupied.
        applyStimulus(1'b1, 32'hAA, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hBB, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("skid_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("async_out_valid", out_valid, 1'b0);
        checkOutput("async_out_data", out_data, BUBBLE);
        checkOutput("async_in_ready", in_ready, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Saturation on the 2-bit instance: one beat, then six stalled cycles.
        s_in_valid = 1'b1;
        @(posedge clk);
        #2;
        s_in_valid = 1'b0;
        s_stall    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #2;
            checkOutput("sat_stall_cnt", s_stall_cnt, (i < 3) ? i : 3);
        end
        s_cnt_clr = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("sat_clr", s_stall_cnt, 2'd0);
        s_cnt_clr = 1'b0;
        s_stall   = 1'b0;

        // Randomised handshakes against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
